// File: rtl/cluster_pmb_receiver.sv
// Cluster-side Power Management Bus endpoint. Each channel deserializes the shared
// serial line and commits full words to its cfg or ctrl register on a write request.
module cluster_pmb_receiver #(
    parameter int NB_CH      = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        pmb_serial_in_i,
    input  logic [NB_CH-1:0]            pmb_shift_en_i,
    input  logic [NB_CH-1:0]            pmb_select_ctr_i,
    input  logic [NB_CH-1:0]            pmb_pmbw_req_i,
    output logic [NB_CH-1:0]            pmb_ack_o,
    output logic [NB_CH-1:0]            pmb_err_o,
    output logic [NB_CH*DATA_WIDTH-1:0] cfg_o,
    output logic [NB_CH*DATA_WIDTH-1:0] ctrl_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_e;

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        state_e                  state_r;
        state_e                  state_s;
        logic [DATA_WIDTH-1:0]   sr_r;
        logic [DATA_WIDTH-1:0]   cfg_r;
        logic [DATA_WIDTH-1:0]   ctrl_r;
        logic [CNT_W-1:0]        cnt_r;
        logic                    ack_r;
        logic                    err_r;
        logic                    commit_s;
        logic                    shift_s;
        logic                    full_s;
        logic                    req_s;

        assign req_s  = pmb_pmbw_req_i[c];
        assign full_s = (cnt_r == CNT_FULL);

        // Handshake next-state: commit only on the IDLE->ACK edge, shift only in quiet IDLE
        always_comb begin
            state_s  = state_r;
            commit_s = 1'b0;
            shift_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        state_s  = ST_ACK;
                        commit_s = 1'b1;
                    end else begin
                        state_s  = ST_IDLE;
                        shift_s  = pmb_shift_en_i[c];
                    end
                end
                ST_ACK: begin
                    if (req_s) begin
                        state_s = ST_WAIT_LOW;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT_LOW: begin
                    if (req_s) begin
                        state_s = ST_WAIT_LOW;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        // Handshake state register
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_s;
            end
        end

        // Shift register, saturating bit counter, target registers and ack/err pulses
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sr_r   <= '0;
                cnt_r  <= '0;
                cfg_r  <= '0;
                ctrl_r <= '0;
                ack_r  <= 1'b0;
                err_r  <= 1'b0;
            end else begin
                ack_r <= commit_s;
                err_r <= commit_s & ~full_s;
                if (commit_s) begin
                    // sr is deliberately kept; only the counter restarts the frame
                    cnt_r <= '0;
                    if (full_s && pmb_select_ctr_i[c]) begin
                        ctrl_r <= sr_r;
                    end else if (full_s) begin
                        cfg_r <= sr_r;
                    end else begin
                        ctrl_r <= ctrl_r;
                    end
                end else if (shift_s) begin
                    sr_r  <= {sr_r[DATA_WIDTH-2:0], pmb_serial_in_i};
                    cnt_r <= full_s ? cnt_r : (cnt_r + CNT_ONE);
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end

        assign pmb_ack_o[c]                            = ack_r;
        assign pmb_err_o[c]                            = err_r;
        assign cfg_o[c*DATA_WIDTH +: DATA_WIDTH]       = cfg_r;
        assign ctrl_o[c*DATA_WIDTH +: DATA_WIDTH]      = ctrl_r;
    end

endmodule
